// File: rtl/zigzag_reorder_pp.sv
// Ping-pong 8x8 coefficient reorder buffer for N_CH lockstep lanes.
// One bank fills in raster order while the other drains in zigzag or raster order.
module zigzag_reorder_pp #(
    parameter int DATA_WIDTH = 10,
    parameter int N_CH       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode_zz,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CH*DATA_WIDTH-1:0] out_data,
    output logic [5:0]                 out_idx,
    output logic                       out_first,
    output logic                       out_last
);

    localparam int W = N_CH * DATA_WIDTH;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Both banks of all lanes share one wide word; address is {bank, index}.
    logic [W-1:0] ram_q [128];

    logic [5:0]   wr_ptr_q, wr_ptr_d;
    logic [5:0]   rd_ptr_q, rd_ptr_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [1:0]   full_q, full_d;
    logic [1:0]   mode_q, mode_d;
    logic         out_valid_q, out_valid_d;
    logic         out_first_q, out_first_d;
    logic         out_last_q, out_last_d;
    logic [5:0]   out_idx_q, out_idx_d;
    logic [W-1:0] out_data_q, out_data_d;

    logic         wr_fire;
    logic         rd_issue;
    logic [5:0]   rd_addr;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign rd_issue = full_q[rd_bank_q] && (!out_valid_q || out_ready);
    assign rd_addr  = mode_q[rd_bank_q] ? ZZ[rd_ptr_q] : rd_ptr_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        mode_d    = mode_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 6'd1;
            if (wr_ptr_q == 6'd0) begin
                mode_d[wr_bank_q] = mode_zz;
            end
            if (wr_ptr_q == 6'd63) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // The read bank is full and the write bank is not, so these never collide.
        rd_ptr_d  = rd_ptr_q;
        rd_bank_d = rd_bank_q;
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + 6'd1;
            if (rd_ptr_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        if (rd_issue) begin
            out_valid_d = 1'b1;
            out_first_d = (rd_ptr_q == 6'd0);
            out_last_d  = (rd_ptr_q == 6'd63);
            out_idx_d   = rd_addr;
            out_data_d  = ram_q[{rd_bank_q, rd_addr}];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            ram_q[{wr_bank_q, wr_ptr_q}] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_zigzag_reorder_pp.sv
// Directed bench for zigzag_reorder_pp: write-side model builds the expected read
// order (zigzag table generated by a diagonal walk) and a negedge monitor scores outputs.
module tb_zigzag_reorder_pp;

    localparam int DW = 10;
    localparam int NC = 3;
    localparam int W  = DW * NC;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode_zz = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [5:0]   out_idx;
    logic         out_first;
    logic         out_last;

    zigzag_reorder_pp #(.DATA_WIDTH(DW), .N_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .mode_zz(mode_zz),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic [5:0]   idx;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         exp_q[$];
    int           zz_tab[64];
    logic [W-1:0] blk_buf[64];
    int           wr_cnt = 0;
    logic         blk_mode = 1'b0;
    int           total_acc = 0;
    int           t_wr0 = -1;
    int           t_v0 = -1;
    int           n_out = 0;
    int           first_out_cyc = 0;
    int           last_out_cyc = 0;

    function automatic logic [W-1:0] din(input int b, input int i);
        return {DW'(i + 200), DW'(i + 100), DW'((i + 64 * (b % 16)) % 1024)};
    endfunction

    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int y = (s < 7 ? s : 7); y >= (s > 7 ? s - 7 : 0); y--) begin
                    zz_tab[k] = y * 8 + (s - y);
                    k++;
                end
            end else begin
                for (int y = (s > 7 ? s - 7 : 0); y <= (s < 7 ? s : 7); y++) begin
                    zz_tab[k] = y * 8 + (s - y);
                    k++;
                end
            end
        end
    endtask

    task automatic push_block();
        exp_t e;
        int a;
        for (int k = 0; k < 64; k++) begin
            a = blk_mode ? zz_tab[k] : k;
            e.d = blk_buf[a];
            e.idx = 6'(a);
            e.f = (k == 0);
            e.l = (k == 63);
            exp_q.push_back(e);
        end
    endtask

    task automatic write_block(input logic m, input int b, input int nwords, input int gap_pct);
        for (int i = 0; i < nwords; i++) begin
            int  waited = 0;
            bit  done = 0;
            in_data = din(b, i);
            mode_zz = (i == 0) ? m : ~m;
            while (!done) begin
                in_valid = ($urandom_range(99) >= gap_pct);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    done = 1;
                    if (wr_cnt == 0) blk_mode = mode_zz;
                    if (t_wr0 < 0) t_wr0 = cyc;
                    blk_buf[wr_cnt] = in_data;
                    wr_cnt++;
                    total_acc++;
                    if (wr_cnt == 64) begin
                        push_block();
                        wr_cnt = 0;
                    end
                end
                waited++;
                if (waited > 2000) begin
                    check("write_timeout", in_ready, 1);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1, "write side stuck");
                end
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output scoreboard and hold-stability monitor
    bit           stall_prev = 0;
    logic [W-1:0] hold_d;
    logic [5:0]   hold_i;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
                check("hold_idx", out_idx, hold_i);
            end
            if (out_valid && t_v0 < 0) t_v0 = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_queue", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_idx", out_idx, e.idx);
                    check("out_first", out_first, e.f);
                    check("out_last", out_last, e.l);
                    n_out++;
                    if (n_out == 1) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_idx;
        end
    end

    initial begin
        int acc0;
        bit wr_done;
        build_zz();

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single zigzag block: latency and order
        out_ready = 1'b1;
        t_wr0 = -1; t_v0 = -1; n_out = 0;
        write_block(1'b1, 0, 64, 0);
        wait_drain();
        check("zz_latency", t_v0 - t_wr0, 65);
        check("zz_count", n_out, 64);

        // Single raster block
        n_out = 0;
        write_block(1'b0, 0, 64, 0);
        wait_drain();
        check("raster_count", n_out, 64);

        // Four back-to-back blocks, alternating order, no bubbles
        n_out = 0;
        for (int b = 1; b <= 4; b++) write_block(b[0], b, 64, 0);
        wait_drain();
        check("b2b_count", n_out, 256);
        check("b2b_no_gap", last_out_cyc - first_out_cyc, 255);

        // Output stalled 200 cycles while input streams
        out_ready = 1'b0;
        n_out = 0;
        acc0 = total_acc;
        fork
            begin
                for (int b = 10; b < 13; b++) write_block(b[0], b, 64, 0);
            end
            begin
                repeat (200) @(posedge clk);
                #1;
                check("stall_accepted", total_acc - acc0, 128);
                check("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_count", n_out, 192);

        // Random handshakes on both sides, 10 blocks
        n_out = 0;
        wr_done = 0;
        fork
            begin
                for (int b = 0; b < 10; b++) write_block(b[1], b + 20, 64, 50);
                wr_done = 1;
            end
            begin
                int n = 0;
                while ((!wr_done || exp_q.size() != 0) && n < 20000) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(1) == 1);
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("rand_count", n_out, 640);

        // Reset in the middle of the third block
        for (int b = 0; b < 2; b++) write_block(b[0], b + 40, 64, 0);
        write_block(1'b1, 42, 30, 0);
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        exp_q.delete();
        wr_cnt = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_out = 0;
        write_block(1'b1, 7, 64, 0);
        wait_drain();
        check("post_reset_count", n_out, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_reorder_pp.md
Name: zigzag_reorder_pp

Overview:
- Multi-channel 8x8 coefficient reorder buffer placed directly after the Dct block.
- Each channel has two 64-entry banks used ping-pong: one bank fills in raster order while the other drains.
- Read order is either zigzag or raster, selected per block.
- Both sides use valid/ready handshakes, so the DCT front end and the downstream entropy coder can stall independently.

Parameters:
- DATA_WIDTH, 10, width of one coefficient.
- N_CH, 3, number of lockstep channels (lanes) sharing the control logic.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; clears all control state.
- mode_zz  in  1  read order: 1 = zigzag, 0 = raster. Sampled on the first write of each block.
- in_valid  in  1  input lane data valid.
- in_ready  out  1  buffer can accept a write this cycle.
- in_data  in  N_CH*DATA_WIDTH  one coefficient per lane; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  output data valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  N_CH*DATA_WIDTH  reordered coefficients, same lane packing as in_data.
- out_idx  out  6  raster index {y,x} of the coefficient on out_data.
- out_first  out  1  high with the first coefficient of a block.
- out_last  out  1  high with the 64th coefficient of a block.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low: rst_n is asserted asynchronously and released synchronously to clk.
- Reset values: wr_ptr=0, rd_ptr=0, wr_bank=0, rd_bank=0, full[1:0]=0, out_valid=0, out_first=0, out_last=0, out_idx=0, out_data=0, in_ready=1 (combinational after reset). RAM contents are not cleared.
- Write side:
  - in_ready = !full[wr_bank].
  - A write fires when in_valid && in_ready. All lanes write in_data to address wr_ptr of bank wr_bank; wr_ptr increments mod 64.
  - On the first write of a block (wr_ptr==0), mode_zz is latched into mode[wr_bank].
  - On the write with wr_ptr==63: full[wr_bank] is set next cycle and wr_bank toggles.
- Read side:
  - Read issue condition: full[rd_bank] && (!out_valid || out_ready).
  - On issue, address = mode[rd_bank] ? ZZ[rd_ptr] : rd_ptr. ZZ is the standard JPEG zigzag table (a constant LUT or an equivalent counter walk).
  - rd_ptr increments mod 64.
  - When rd_ptr==63 is issued: full[rd_bank] clears next cycle and rd_bank toggles.
- Output register:
  - One cycle after an issue: out_valid=1, out_data = RAM word, out_idx = address, out_first = (issued rd_ptr==0), out_last = (issued rd_ptr==63).
  - If out_valid && !out_ready: all outputs hold and no read issues.
  - If no issue and out_ready: out_valid drops to 0.
- Latency: first write of an empty buffer at cycle 0, continuous input → full visible at cycle 64, first issue at 64, out_valid at 65. Continuous throughput is one coefficient per cycle with no bubble between blocks.
- Boundaries:
  - Both banks full: in_ready=0 and input stalls. The input bank is never overwritten while unread.
  - A fill completing and a drain completing in the same cycle update different full bits; both take effect.
  - A write to the bank that is freed in the same cycle is not allowed; in_ready reflects the registered full bit.
  - mode_zz changes mid-block are ignored until the next block start.
  - Reset mid-block discards all partial and full blocks; the first post-reset write is address 0 of bank 0.

Test Plan:
- Single block, mode_zz=1, lane0 data = raster index, out_ready=1 → out_valid first at cycle 65; out_data lane0 sequence 0,1,8,16,9,2,3,10,17,24,…,63; out_first on 0, out_last on 63.
- Single block, mode_zz=0 → out_data lane0 = 0..63 in order, out_idx = out_data. Lanes 1 and 2 carry index+100 and index+200 correctly.
- Four back-to-back blocks, alternating mode_zz, out_ready=1 → 256 outputs with no gap after cycle 65; each block reads in the order latched at its first write.
- out_ready=0 held for 200 cycles while input streams → in_ready falls after 128 accepted writes. Release out_ready → all 128 values appear in order, none lost.
- Random out_ready (50%) plus random in_valid, 10 blocks → scoreboard matches a reference reorder model, and out_data is stable while out_valid && !out_ready.
- Assert rst_n at write 30 of block 2 → out_valid=0 and in_ready=1 immediately. A fresh block then reads out correctly starting at out_first.
